port_a_ctrl: RTL
================

Name: port_a_ctrl

Overview:
Register-file front end for PIC16F84 port A. It decodes core accesses to PORTA (file 0x05, bank 0) and TRISA (file 0x85, bank 1), and holds the TRISA and output-latch registers. It drives tris_val[4:0] into the port A tristate block. It also synchronizes the pin inputs for PORTA reads and produces the TMR0 external-clock edge pulse from RA4/T0CKI.

Parameters:
PORTA_ADDR, 7'h05, file address of PORTA/TRISA; rp0 selects between them.
SYNC_STAGES, 2, flop stages on pin inputs (legal range 2..3).
RESET_TRIS, 5'h1F, TRISA value after reset (all inputs).

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
rp0  input  1  STATUS.RP0 bank select (0=PORTA, 1=TRISA)
addr  input  7  file register address from core
wr_en  input  1  write strobe, one cycle per write
wr_mask  input  8  per-bit write enable (8'hFF = full write; one-hot = BSF/BCF)
wdata  input  8  write data
rd_en  input  1  read strobe
rdata  output  8  read data, valid with rd_valid
rd_valid  output  1  one-cycle pulse, read data valid
pin_in  input  5  raw RA4..RA0 pin levels (asynchronous)
tris_val  output  5  TRISA register (1 = input) to tristate block
lat_out  output  5  PORTA output latch
ra4_pull_low  output  1  RA4 open-drain pulldown enable
t0se  input  1  OPTION.T0SE (0 = rising edge, 1 = falling edge)
t0cki_pulse  output  1  one-cycle TMR0 increment request

Behaviour:
- Reset (rst=1 at clk edge):
  - tris_val=RESET_TRIS; lat_out=5'h00; rdata=8'h00; rd_valid=0; t0cki_pulse=0.
  - Synchronizer flops and edge-detect history clear to 0.
  - Accesses in the reset cycle are ignored.
  - Reset asserted mid-access cancels a pending rd_valid.
- Decode: hit = (addr==PORTA_ADDR). Target is PORTA when rp0=0, TRISA when rp0=1. A non-hit access has no effect and gives no rd_valid.
- Write (wr_en & hit):
  - Takes effect at the next clk edge.
  - Per bit i<5: reg[i] <= wr_mask[i] ? wdata[i] : reg[i].
  - Bits 7:5 are unimplemented and discarded.
  - A PORTA write updates lat_out whatever the TRIS state.
- Read (rd_en & hit):
  - Latency 1: rdata and rd_valid register on the next edge; rd_valid is high for exactly 1 cycle.
  - PORTA read returns {3'b000, pin_sync[4:0]}, i.e. synchronized pin levels (not the latch), for input and output pins alike.
  - TRISA read returns {3'b000, tris_val}.
  - Between reads rdata holds its last value.
- Simultaneous rd_en & wr_en to the same register: the read returns the pre-write value; the write still commits.
- Back-to-back reads every cycle are supported with no bubbles.
- Synchronizer: pin_sync = pin_in delayed SYNC_STAGES clocks.
- ra4_pull_low = ~tris_val[4] & ~lat_out[4], registered from the same state. RA4 never drives high.
- T0CKI edge detect on pin_sync[4], with history flop h:
  - t0se=0: pulse when pin_sync[4]&~h.
  - t0se=1: pulse when ~pin_sync[4]&h.
  - The pulse is one cycle and registered, so it arrives SYNC_STAGES+1 clocks after the pin edge.
  - Active regardless of tris_val[4].
  - A t0se change does not itself generate a pulse.
- Pin glitches shorter than one clk may be missed; this is not required to be detected.

Test Plan:
1. Reset -> tris_val=5'h1F, lat_out=0, ra4_pull_low=0, rd_valid=0. Then rp0=1, read 0x05 -> rdata=8'h1F and rd_valid=1 exactly one cycle later.
2. rp0=1, write 0x05 wdata=8'hE0 mask=8'hFF -> tris_val=5'h00. Then rp0=0, write 8'h0A -> lat_out=5'h0A, ra4_pull_low=1. Next, write 8'h10 -> ra4_pull_low=0.
3. With tris=5'h00 and lat=5'h15: BCF-style write mask=8'h04, wdata=8'h00 -> lat_out=5'h11. BSF mask=8'h02, wdata=8'h02 -> lat_out=5'h13. Other bits unchanged.
4. pin_in=5'h0C applied -> PORTA read issued 3 cycles later returns 8'h0C. A read issued 1 cycle after the pin change returns the old value.
5. Same cycle: rp0=1, read and write 0x05 with wdata=8'h03 while TRISA=5'h1F -> rdata=8'h1F; following read returns 8'h03.
6. t0se=0: RA4 0->1 -> single t0cki_pulse 3 clocks later; 1->0 gives none. t0se=1: the reverse. Assert rst during the pipeline -> no pulse.

Source files
------------

// File: rtl/port_a_ctrl.sv
// PIC16F84 port A register front end: PORTA/TRISA decode, output latch and TRIS
// registers, pin input synchronizer and RA4/T0CKI edge pulse for TMR0.
module port_a_ctrl #(
   parameter logic [6:0] PORTA_ADDR  = 7'h05,
   parameter int         SYNC_STAGES = 2,
   parameter logic [4:0] RESET_TRIS  = 5'h1F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rp0,
   input  logic [6:0] addr,
   input  logic       wr_en,
   input  logic [7:0] wr_mask,
   input  logic [7:0] wdata,
   input  logic       rd_en,
   output logic [7:0] rdata,
   output logic       rd_valid,
   input  logic [4:0] pin_in,
   output logic [4:0] tris_val,
   output logic [4:0] lat_out,
   output logic       ra4_pull_low,
   input  logic       t0se,
   output logic       t0cki_pulse
);

   logic [4:0] r_tris;
   logic [4:0] r_lat;
   logic [7:0] r_rdata;
   logic       r_rd_valid;
   logic       r_ra4_pull;
   logic       r_t0_hist;
   logic       r_t0_pulse;
   logic [4:0] r_sync [SYNC_STAGES];

   logic       w_hit;
   logic       w_wr_porta;
   logic       w_wr_trisa;
   logic       w_rd_hit;
   logic [4:0] w_pin_sync;
   logic [4:0] w_tris_nxt;
   logic [4:0] w_lat_nxt;
   logic [7:0] w_rd_data;
   logic       w_t0_edge;
   logic       w_unused;

   // Bits 7:5 of the data path are unimplemented on port A.
   assign w_unused   = ^{wdata[7:5], wr_mask[7:5]};

   assign w_hit      = (addr == PORTA_ADDR);
   assign w_wr_porta = wr_en & w_hit & ~rp0;
   assign w_wr_trisa = wr_en & w_hit & rp0;
   assign w_rd_hit   = rd_en & w_hit;
   assign w_pin_sync = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_tris_nxt = r_tris;
      w_lat_nxt  = r_lat;
      if (w_wr_trisa) w_tris_nxt = (r_tris & ~wr_mask[4:0]) | (wdata[4:0] & wr_mask[4:0]);
      if (w_wr_porta) w_lat_nxt  = (r_lat  & ~wr_mask[4:0]) | (wdata[4:0] & wr_mask[4:0]);
   end

   // Reads see the register state before any same-cycle write commits.
   assign w_rd_data = rp0 ? {3'b000, r_tris} : {3'b000, w_pin_sync};

   assign w_t0_edge = t0se ? (~w_pin_sync[4] & r_t0_hist) : (w_pin_sync[4] & ~r_t0_hist);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tris     <= RESET_TRIS;
         r_lat      <= 5'h00;
         r_rdata    <= 8'h00;
         r_rd_valid <= 1'b0;
         r_ra4_pull <= ~RESET_TRIS[4];
         r_t0_hist  <= 1'b0;
         r_t0_pulse <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 5'h00;
      end else begin
         r_tris     <= w_tris_nxt;
         r_lat      <= w_lat_nxt;
         r_rd_valid <= w_rd_hit;
         if (w_rd_hit) r_rdata <= w_rd_data;
         // Registered from next-state so it always tracks tris_val/lat_out.
         r_ra4_pull <= ~w_tris_nxt[4] & ~w_lat_nxt[4];
         r_t0_hist  <= w_pin_sync[4];
         r_t0_pulse <= w_t0_edge;
         r_sync[0]  <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign rdata        = r_rdata;
   assign rd_valid     = r_rd_valid;
   assign tris_val     = r_tris;
   assign lat_out      = r_lat;
   assign ra4_pull_low = r_ra4_pull;
   assign t0cki_pulse  = r_t0_pulse;

endmodule
